// File: rtl/tx_packet_scheduler.sv
// Arbitrates handshake and host data packet requests toward the TX controller and enforces the inter-packet gap.
// Optional build macro TXSCHED_START_TIMEOUT_EN adds a start timeout in ISSUE that reports through err_code[1].
module tx_packet_scheduler #(
   parameter int IPG_CYCLES    = 16,
   parameter int START_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       hs_req,
   input  logic [1:0] hs_type,
   input  logic       host_req,
   input  logic       host_data1,
   input  logic [6:0] buffer_occupancy,
   input  logic       tx_transfer_active,
   input  logic       tx_error,
   input  logic       err_clr,
   output logic [2:0] tx_packet,
   output logic       hs_grant,
   output logic       host_grant,
   output logic       sched_busy,
   output logic [1:0] err_code
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;
   localparam logic [1:0] ST_GAP       = 2'd3;

   localparam logic [2:0] PKT_NONE  = 3'd0;
   localparam logic [2:0] PKT_DATA0 = 3'd1;
   localparam logic [2:0] PKT_DATA1 = 3'd2;
   localparam logic [2:0] PKT_ACK   = 3'd3;
   localparam logic [2:0] PKT_NAK   = 3'd4;
   localparam logic [2:0] PKT_STALL = 3'd5;

   // One counter serves both the GAP countdown and the ISSUE timeout, so it is sized for the larger.
   localparam int CNT_MAX = (IPG_CYCLES > START_TIMEOUT) ? IPG_CYCLES : START_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(IPG_CYCLES - 1);
`ifdef TXSCHED_START_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TIMEOUT - 1);
`endif

   logic [1:0]       state_reg, state_next;
   logic [2:0]       pkt_reg, pkt_next;
   logic             hs_grant_reg, hs_grant_next;
   logic             host_grant_reg, host_grant_next;
   logic             busy_reg, busy_next;
   logic [1:0]       err_reg, err_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             ready_reg;
   logic [2:0]       hs_code;
   logic             host_eligible;
   logic             tx_err_set;
   logic             timeout_set;

   always_comb begin
      case (hs_type)
         2'd0:    hs_code = PKT_ACK;
         2'd1:    hs_code = PKT_NAK;
         2'd2:    hs_code = PKT_STALL;
         default: hs_code = PKT_NAK;
      endcase
   end

   assign host_eligible = host_req && (buffer_occupancy != '0);
   assign tx_err_set    = tx_error && ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT_DONE));

   always_comb begin
      state_next      = state_reg;
      pkt_next        = pkt_reg;
      hs_grant_next   = 1'b0;
      host_grant_next = 1'b0;
      cnt_next        = cnt_reg;
      timeout_set     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // ready_reg holds off arbitration for the first edge after reset release.
            if (ready_reg) begin
               if (hs_req) begin
                  state_next    = ST_ISSUE;
                  hs_grant_next = 1'b1;
                  pkt_next      = hs_code;
                  cnt_next      = '0;
               end else if (host_eligible) begin
                  state_next      = ST_ISSUE;
                  host_grant_next = 1'b1;
                  pkt_next        = host_data1 ? PKT_DATA1 : PKT_DATA0;
                  cnt_next        = '0;
               end
            end
         end
         ST_ISSUE: begin
            if (tx_transfer_active) begin
               state_next = ST_WAIT_DONE;
               pkt_next   = PKT_NONE;
            end
`ifdef TXSCHED_START_TIMEOUT_EN
            else if (cnt_reg == TO_LAST) begin
               state_next  = ST_GAP;
               pkt_next    = PKT_NONE;
               cnt_next    = GAP_LOAD;
               timeout_set = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
`endif
         end
         ST_WAIT_DONE: begin
            if (!tx_transfer_active) begin
               state_next = ST_GAP;
               cnt_next   = GAP_LOAD;
            end
         end
         default: begin
            if (cnt_reg == '0) begin
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt_reg - CNT_ONE;
            end
         end
      endcase
      busy_next = (state_next != ST_IDLE);
      // A new error event outranks a clear arriving on the same edge.
      err_next[0] = tx_err_set  | (err_reg[0] & ~err_clr);
      err_next[1] = timeout_set | (err_reg[1] & ~err_clr);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg      <= ST_IDLE;
         pkt_reg        <= PKT_NONE;
         hs_grant_reg   <= 1'b0;
         host_grant_reg <= 1'b0;
         busy_reg       <= 1'b0;
         err_reg        <= 2'b00;
         cnt_reg        <= '0;
         ready_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pkt_reg        <= pkt_next;
         hs_grant_reg   <= hs_grant_next;
         host_grant_reg <= host_grant_next;
         busy_reg       <= busy_next;
         err_reg        <= err_next;
         cnt_reg        <= cnt_next;
         ready_reg      <= 1'b1;
      end
   end

   assign tx_packet  = pkt_reg;
   assign hs_grant   = hs_grant_reg;
   assign host_grant = host_grant_reg;
   assign sched_busy = busy_reg;
   assign err_code   = err_reg;

endmodule
